synchronous_fifo_multi_push: RTL

- Synchronous FIFO, write side is wide: up to MULTI_PUSH entries accepted per cycle; read side pops one entry per cycle.
- Used where a wide producer (fetch/decode group, bus beat unpacker) feeds a narrow consumer. It is the dual of the multi-pop FIFO.
- Show-ahead read port: the head entry is always visible while valid=1.
- Circular buffer. All DEPTH slots are usable.

---
 rtl/synchronous_fifo_multi_push.sv | 118 +++++++++++
 1 files changed

// File: rtl/synchronous_fifo_multi_push.sv
// Synchronous FIFO: up to MULTI_PUSH writes per cycle, one show-ahead pop.
// Ports: clk, rst (async active-low), push_cnt/data_in, pop, data_out, valid, count, free_cnt, full, err_*.
module synchronous_fifo_multi_push #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8,
    parameter int MULTI_PUSH = 4,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = $clog2(MULTI_PUSH + 1),
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [PW-1:0]                         push_cnt,
    input  logic [MULTI_PUSH-1:0][DATA_WIDTH-1:0] data_in,
    input  logic                                  pop,
    output logic [DATA_WIDTH-1:0]                 data_out,
    output logic                                  valid,
    output logic [CW-1:0]                         count,
    output logic [CW-1:0]                         free_cnt,
    output logic                                  full,
    output logic                                  err_overflow,
    output logic                                  err_underflow
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;

    logic [CW-1:0] free;
    logic          push_ok;
    logic          pop_ok;
    logic [AW-1:0] wr_idx [MULTI_PUSH];
    logic          wr_en  [MULTI_PUSH];

    // Sums never reach 2*DEPTH, so one conditional subtract wraps them.
    function automatic logic [AW-1:0] wrap(input logic [31:0] s);
        wrap = (s >= 32'(DEPTH)) ? AW'(s - 32'(DEPTH)) : AW'(s);
    endfunction

    always_comb begin
        free    = CW'(DEPTH) - count_q;
        // Whole group is taken or dropped; the slot freed by pop is not reused.
        push_ok = (32'(push_cnt) <= 32'(MULTI_PUSH)) &&
                  (32'(push_cnt) <= 32'(free));
        pop_ok  = pop && (count_q != '0);

        for (int i = 0; i < MULTI_PUSH; i++) begin
            wr_idx[i] = wrap(32'(wr_ptr_q) + 32'(i));
            wr_en[i]  = push_ok && (32'(i) < 32'(push_cnt));
        end

        wr_ptr_d = wr_ptr_q;
        if (push_ok) begin
            wr_ptr_d = wrap(32'(wr_ptr_q) + 32'(push_cnt));
        end

        rd_ptr_d = rd_ptr_q;
        if (pop_ok) begin
            rd_ptr_d = wrap(32'(rd_ptr_q) + 32'd1);
        end

        count_d = count_q
                + (push_ok ? CW'(push_cnt) : '0)
                - (pop_ok  ? CW'(1)        : '0);

        ovf_d = ovf_q | ~push_ok;
        udf_d = udf_q | (pop && (count_q == '0));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage is deliberately not reset; it is masked while empty.
    always_ff @(posedge clk) begin
        for (int i = 0; i < MULTI_PUSH; i++) begin
            if (wr_en[i]) begin
                mem_q[wr_idx[i]] <= data_in[i];
            end
        end
    end

    assign valid         = (count_q != '0);
    assign data_out      = valid ? mem_q[rd_ptr_q] : '0;
    assign count         = count_q;
    assign free_cnt      = free;
    assign full          = (count_q == CW'(DEPTH));
    assign err_overflow  = ovf_q;
    assign err_underflow = udf_q;

    a_count_bound : assert property (
        @(posedge clk) disable iff (!rst)
        32'(count_q) <= 32'(DEPTH)
    );

    a_ptr_count : assert property (
        @(posedge clk) disable iff (!rst)
        ((32'(wr_ptr_q) + 32'(DEPTH) - 32'(rd_ptr_q)) % 32'(DEPTH))
            == (32'(count_q) % 32'(DEPTH))
    );

endmodule
